ham_rx_deser: RTL and testbench
===============================

// Module: ham_rx_deser
// PURPOSE
//   Serial receive front end for the Hamming(12,8) link. It samples a framed
//   serial line on bit strobes and assembles 12-bit codewords. Each codeword is
//   presented on a valid/ready interface to the Hamming decoder, which sits
//   directly downstream.
//   It also reports framing errors and overruns caused by decoder back-pressure.
// PARAMETERS
//   DATA_W   12          codeword width in bits; the frame carries exactly DATA_W data bits
//   CNT_W    4           bit-counter width; must satisfy 2**CNT_W >= DATA_W
// PORTS
//   clk         in   1       single clock, rising edge
//   reset       in   1       asynchronous, active-high
//   bit_stb     in   1       qualifies ser_in for one clk cycle; at most one per cycle
//   ser_in      in   1       serial line; idles high
//   code_out    out  [1:DATA_W]  assembled codeword; index 1 = first data bit received
//   code_valid  out  1       code_out holds an unconsumed codeword
//   code_ready  in   1       decoder accepts code_out when code_valid && code_ready
//   frame_err   out  1       1-cycle pulse: stop bit sampled low
//   overrun     out  1       1-cycle pulse: a completed frame was dropped because the buffer was full
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, bit count=0, shift reg=0,
//     code_out=0, code_valid=0, frame_err=0, overrun=0.
//   Reset mid-frame discards the partial frame and any buffered codeword.
//   Frame format: start(0), DATA_W data bits with index 1 first, stop(1).
//   All sampling happens only on cycles with bit_stb=1. Cycles without bit_stb
//     hold every state, counter, and shift value.
//   FSM:
//     IDLE  : on bit_stb && ser_in==0 -> DATA, count=0.
//     DATA  : on bit_stb, shift[count+1]=ser_in and count++.
//             After DATA_W bits -> STOP.
//     STOP  : on bit_stb && ser_in==1 -> frame complete -> IDLE.
//             On bit_stb && ser_in==0 -> frame_err pulse, frame discarded -> BREAK.
//     BREAK : on bit_stb && ser_in==1 -> IDLE. A low line never starts a frame here.
//   Frame completion, in the cycle after the stop-bit strobe:
//     If code_valid==0, or the buffer is consumed in that same cycle
//       (code_valid && code_ready): code_out=shift and code_valid=1.
//       Simultaneous consume and load is lossless.
//     Otherwise: overrun pulses for 1 cycle. The new codeword is dropped and
//       the old code_out is retained.
//   Handshake: code_out and code_valid are registered. code_out is stable while
//     code_valid=1 && code_ready=0. code_valid falls the cycle after the
//     handshake, unless a new load occurs in that cycle.
//   Latency: code_valid rises 1 clk after the stop-bit strobe.
//   frame_err and overrun are registered, never asserted together, and cleared
//     on the next cycle.
//   No payload checking is done here. Parity and correction belong to the
//     decoder.
// STRUCTURE
//   Shared package ham_pkg holds:
//     - DATA_W=12 and the data width 8
//     - the FSM state enum {IDLE, DATA, STOP, BREAK}
//     - START_BIT=0 and STOP_BIT=1 constants
//   One natural sub-module: ham_rx_buf. It is the 1-entry valid/ready output
//     register with load, overrun detect, and simultaneous load/consume. The
//     FSM, counter, and shift register stay in ham_rx_deser.
// TESTING
//   1. After reset, send frame 0,{101100111000},1 with code_ready=1.
//      -> code_out=12'b101100111000, code_valid high exactly 1 cycle,
//         1 clk after the stop strobe.
//   2. Send frame with stop bit 0.
//      -> frame_err pulses once and code_valid stays 0.
//      Then hold ser_in=0 for 3 strobes followed by 1, then a valid frame.
//      -> no start while in BREAK; the valid frame is received correctly.
//   3. With code_ready=0, send two frames A=12'hA5C then B=12'h3F0.
//      -> code_out=12'hA5C held, overrun pulses on B.
//      Raise code_ready -> A is consumed and B never appears.
//   4. Raise code_ready in the exact cycle the second frame completes.
//      -> A is consumed, B loads, code_valid stays 1, no overrun.
//   5. Assert reset in the 6th data bit.
//      -> all outputs 0 immediately (async). After release, a full frame
//         decodes correctly with no stale bits.
//   6. Insert gaps of 0-5 idle clks between strobes.
//      -> identical code_out to the back-to-back strobe case.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared constants and types for the Hamming(12,8) serial receive path.
package ham_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned MSG_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    BREAK
  } rxState_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ham_rx_buf.sv
// One-entry valid/ready output register. A new codeword is only accepted when
// the slot is empty or being drained in the same cycle; otherwise it is dropped.
module ham_rx_buf #(
  parameter int unsigned DATA_W = ham_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [1:DATA_W] loadData,
  input  logic          ready,
  output logic [1:DATA_W] data,
  output logic          valid,
  output logic          overrun
);

  logic accept;

  always_comb begin
    accept = load && (!valid || ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && !accept;
      if (accept) begin
        data  <= loadData;
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ham_rx_deser.sv
// Framed serial receiver: start bit, DATA_W data bits (index 1 first), stop bit.
// Completed frames go straight into the output buffer in the stop-bit cycle.
module ham_rx_deser
  import ham_pkg::*;
#(
  parameter int unsigned DATA_W = ham_pkg::DATA_W,
  parameter int unsigned CNT_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bit_stb,
  input  logic            ser_in,
  output logic [1:DATA_W] code_out,
  output logic            code_valid,
  input  logic            code_ready,
  output logic            frame_err,
  output logic            overrun
);

  rxState_t        state;
  logic [CNT_W-1:0] bitCnt;
  logic [1:DATA_W]  shiftReg;
  logic             frameDone;

  always_comb begin
    frameDone = bit_stb && (state == STOP) && (ser_in == STOP_BIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (bit_stb) begin
        case (state)
          IDLE: begin
            if (ser_in == START_BIT) begin
              state  <= DATA;
              bitCnt <= '0;
            end
          end
          DATA: begin
            for (int unsigned i = 1; i <= DATA_W; i++) begin
              if (bitCnt == CNT_W'(i - 1)) shiftReg[i] <= ser_in;
            end
            bitCnt <= bitCnt + CNT_W'(1);
            if (bitCnt == CNT_W'(DATA_W - 1)) state <= STOP;
          end
          STOP: begin
            if (ser_in == STOP_BIT) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
          BREAK: begin
            // a held-low line must go high before a new start bit counts
            if (ser_in == STOP_BIT) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  ham_rx_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (frameDone),
    .loadData(shiftReg),
    .ready   (code_ready),
    .data    (code_out),
    .valid   (code_valid),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_ham_rx_deser.sv
// Scoreboard bench for ham_rx_deser: directed scenarios plus randomized frames,
// with a transaction-level model of the one-entry output slot.
module tb_ham_rx_deser;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         bit_stb = 1'b0;
  logic         ser_in = 1'b1;
  logic         code_ready = 1'b0;
  logic [1:W]   code_out;
  logic         code_valid;
  logic         frame_err;
  logic         overrun;

  ham_rx_deser #(
    .DATA_W(W),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_stb   (bit_stb),
    .ser_in    (ser_in),
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passed = 0;
  int         evtKind = 0;
  logic [1:W] evtWord = '0;
  bit         mdlValid = 1'b0;
  bit         mdlFe = 1'b0;
  bit         mdlOv = 1'b0;
  bit         consume;
  bit         randReady = 1'b0;
  logic [1:W] expQ[$];
  logic [1:W] gotQ[$];
  logic [1:W] refQ[$];
  logic [1:W] sentQ[$];
  int         feSeen = 0;
  int         ovSeen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model of the output slot: a completed frame is taken if the slot is empty
  // or drained on the same edge, otherwise it is reported as an overrun.
  always @(posedge clk) begin
    if (reset) begin
      mdlValid = 1'b0;
      mdlFe    = 1'b0;
      mdlOv    = 1'b0;
      expQ.delete();
    end else begin
      consume = mdlValid && code_ready;
      mdlFe   = (evtKind == 2);
      mdlOv   = 1'b0;
      if (evtKind == 1) begin
        if (!mdlValid || consume) begin
          expQ.push_back(evtWord);
          mdlValid = 1'b1;
        end else begin
          mdlOv = 1'b1;
        end
      end else if (consume) begin
        mdlValid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("code_valid", 32'(code_valid), 32'(mdlValid));
      chk("frame_err", 32'(frame_err), 32'(mdlFe));
      chk("overrun", 32'(overrun), 32'(mdlOv));
      if (frame_err) feSeen++;
      if (overrun) ovSeen++;
      if (code_valid) begin
        chk("word_expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          chk("code_out", 32'(code_out), 32'(expQ[0]));
          if (code_ready) void'(expQ.pop_front());
        end
        if (code_ready) gotQ.push_back(code_out);
      end
    end
  end

  task automatic cyc(input logic stb, input logic b, input int kind, input logic [1:W] w);
    @(posedge clk);
    #1;
    bit_stb = stb;
    ser_in  = b;
    evtKind = kind;
    evtWord = w;
    if (randReady) code_ready = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'($urandom), 0, '0);
  endtask

  task automatic gapStb(input logic b, input int maxGap);
    idle(int'($urandom_range(maxGap, 0)));
    cyc(1'b1, b, 0, '0);
  endtask

  task automatic sendBits(input logic [1:W] w, input int maxGap);
    gapStb(1'b0, maxGap);
    for (int i = 1; i <= int'(W); i++) gapStb(w[i], maxGap);
  endtask

  task automatic stopBit(input logic [1:W] w, input logic good, input int maxGap);
    idle(int'($urandom_range(maxGap, 0)));
    cyc(1'b1, good, good ? 1 : 2, w);
  endtask

  task automatic sendFrame(input logic [1:W] w, input logic good, input int maxGap);
    sendBits(w, maxGap);
    stopBit(w, good, maxGap);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:W] a;
    logic [1:W] b;
    logic [1:W] w;
    int         fe0;
    int         ov0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_code_out", 32'(code_out), 32'd0);
    chk("rst_code_valid", 32'(code_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    // 1: basic frame, consumed immediately
    code_ready = 1'b1;
    gotQ.delete();
    sendFrame(12'b101100111000, 1'b1, 0);
    idle(2);
    chk("t1_count", 32'(gotQ.size()), 32'd1);
    chk("t1_word", 32'(gotQ[0]), 32'(12'b101100111000));

    // 2: bad stop bit, held-low line, then a good frame
    gotQ.delete();
    fe0 = feSeen;
    sendFrame(12'h5A3, 1'b0, 0);
    repeat (3) cyc(1'b1, 1'b0, 0, '0);
    cyc(1'b1, 1'b1, 0, '0);
    idle(1);
    chk("t2_frame_err", 32'(feSeen - fe0), 32'd1);
    chk("t2_none", 32'(gotQ.size()), 32'd0);
    sendFrame(12'h9C6, 1'b1, 0);
    idle(2);
    chk("t2_count", 32'(gotQ.size()), 32'd1);
    chk("t2_word", 32'(gotQ[0]), 32'h9C6);

    // 3: back-pressure drops the second frame
    code_ready = 1'b0;
    gotQ.delete();
    ov0 = ovSeen;
    a = 12'hA5C;
    b = 12'h3F0;
    sendFrame(a, 1'b1, 0);
    sendFrame(b, 1'b1, 0);
    idle(3);
    chk("t3_held", 32'(code_out), 32'(a));
    chk("t3_overrun", 32'(ovSeen - ov0), 32'd1);
    code_ready = 1'b1;
    idle(3);
    chk("t3_count", 32'(gotQ.size()), 32'd1);
    chk("t3_word", 32'(gotQ[0]), 32'(a));

    // 4: consume and load on the same edge
    code_ready = 1'b0;
    gotQ.delete();
    ov0 = ovSeen;
    a = 12'h1E7;
    b = 12'hC38;
    sendFrame(a, 1'b1, 0);
    sendBits(b, 0);
    stopBit(b, 1'b1, 0);
    code_ready = 1'b1;
    idle(1);
    code_ready = 1'b0;
    chk("t4_valid", 32'(code_valid), 32'd1);
    chk("t4_word_b", 32'(code_out), 32'(b));
    idle(2);
    chk("t4_hold_b", 32'(code_out), 32'(b));
    code_ready = 1'b1;
    idle(2);
    chk("t4_overrun", 32'(ovSeen - ov0), 32'd0);
    chk("t4_count", 32'(gotQ.size()), 32'd2);
    chk("t4_first", 32'(gotQ[0]), 32'(a));
    chk("t4_second", 32'(gotQ[1]), 32'(b));

    // 5: async reset during the 6th data bit with a codeword buffered
    code_ready = 1'b0;
    sendFrame(12'h777, 1'b1, 0);
    cyc(1'b1, 1'b0, 0, '0);
    repeat (5) cyc(1'b1, 1'b1, 0, '0);
    cyc(1'b1, 1'b1, 0, '0);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_code_out", 32'(code_out), 32'd0);
    chk("t5_code_valid", 32'(code_valid), 32'd0);
    chk("t5_frame_err", 32'(frame_err), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd0);
    bit_stb = 1'b0;
    ser_in  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    code_ready = 1'b1;
    gotQ.delete();
    sendFrame(12'h041, 1'b1, 0);
    idle(2);
    chk("t5_count", 32'(gotQ.size()), 32'd1);
    chk("t5_word", 32'(gotQ[0]), 32'h041);

    // 6: strobe gaps must not change the received words
    sentQ.delete();
    for (int k = 0; k < 16; k++) sentQ.push_back(W'($urandom));
    gotQ.delete();
    foreach (sentQ[k]) sendFrame(sentQ[k], 1'b1, 0);
    idle(2);
    refQ = gotQ;
    gotQ.delete();
    foreach (sentQ[k]) sendFrame(sentQ[k], 1'b1, 5);
    idle(2);
    chk("t6_count", 32'(gotQ.size()), 32'(sentQ.size()));
    foreach (refQ[k]) chk("t6_word", 32'(gotQ[k]), 32'(refQ[k]));

    // Randomized frames, gaps, bad stops and back-pressure
    randReady = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w = W'($urandom);
      if ($urandom_range(7, 0) == 0) begin
        sendFrame(w, 1'b0, 3);
        cyc(1'b1, 1'b1, 0, '0);
      end else begin
        sendFrame(w, 1'b1, 3);
      end
    end
    randReady = 1'b0;
    code_ready = 1'b1;
    idle(4);
    chk("drain_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
